ifetch_unit: RTL and testbench

IFETCH_UNIT -- requirements
Module: ifetch_unit

---
 rtl/ifetch_if.sv | 33 +++
 rtl/ifetch_unit.sv | 104 ++++++++++
 tb/tb_ifetch_unit.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_if.sv
// Bundle of the fetch-address, instruction-memory and instruction-delivery
// signals between ifetch_unit (master) and its environment (slave).
interface ifetch_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      addr_in;
  logic             addr_valid;
  logic             addr_ready;
  logic             flush;
  logic [31:0]      mem_addr;
  logic             mem_rd;
  logic             mem_ack;
  logic [31:0]      mem_data;
  logic [31:0]      instr;
  logic [31:0]      instr_addr;
  logic             instr_valid;
  logic             instr_ready;
  logic             err_align;
  logic             err_timeout;
  logic [CNT_W-1:0] fetch_cnt;

  modport master (
    input  addr_in, addr_valid, flush, mem_ack, mem_data, instr_ready,
    output addr_ready, mem_addr, mem_rd, instr, instr_addr, instr_valid,
           err_align, err_timeout, fetch_cnt
  );

  modport slave (
    output addr_in, addr_valid, flush, mem_ack, mem_data, instr_ready,
    input  addr_ready, mem_addr, mem_rd, instr, instr_addr, instr_valid,
           err_align, err_timeout, fetch_cnt
  );
endinterface

// File: rtl/ifetch_unit.sv
// Single-entry instruction fetch unit: accepts a PC, issues one memory read,
// holds the returned word until consumed; handles misalignment, timeout, flush.
module ifetch_unit #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input logic      i_clk,
  input logic      i_rst,
  ifetch_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FULL} state_t;

  localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);

  state_t           r_state;
  state_t           w_next;
  logic [31:0]      r_addr;
  logic [31:0]      r_instr;
  logic [31:0]      r_instr_addr;
  logic [7:0]       r_tcnt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err_align;
  logic             r_err_to;
  logic             w_ready;
  logic             w_accept;
  logic             w_aligned;
  logic             w_busy_wait;

  assign w_accept    = bus.addr_valid && w_ready;
  assign w_aligned   = (bus.addr_in[1:0] == 2'b00);
  assign w_busy_wait = (r_state == S_BUSY) && !bus.flush && !bus.mem_ack;

  // state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // next-state logic
  always_comb begin
    w_next = r_state;
    if (bus.flush) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) w_next = w_aligned ? S_BUSY : S_IDLE;
        S_BUSY: begin
          if (bus.mem_ack)          w_next = S_FULL;
          else if (r_tcnt == TLAST) w_next = S_IDLE;
        end
        S_FULL: if (bus.instr_ready) w_next = (w_accept && w_aligned) ? S_BUSY : S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // state-decoded outputs; ADDR_READY drops combinationally under flush or reset
  always_comb begin
    w_ready         = ((r_state == S_IDLE) || ((r_state == S_FULL) && bus.instr_ready))
                      && !bus.flush && !i_rst;
    bus.addr_ready  = w_ready;
    bus.mem_rd      = (r_state == S_BUSY);
    bus.instr_valid = (r_state == S_FULL);
  end

  // address latch, timeout counter, captured word, error pulses, fetch count
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_addr       <= '0;
      r_instr      <= '0;
      r_instr_addr <= '0;
      r_tcnt       <= '0;
      r_cnt        <= '0;
      r_err_align  <= 1'b0;
      r_err_to     <= 1'b0;
    end else begin
      r_err_align <= w_accept && !w_aligned;
      r_err_to    <= w_busy_wait && (r_tcnt == TLAST);
      if (bus.flush) begin
        r_tcnt <= '0;
      end else if (w_accept && w_aligned) begin
        r_addr <= bus.addr_in;
        r_tcnt <= '0;
      end else if (w_busy_wait) begin
        r_tcnt <= (r_tcnt == TLAST) ? 8'd0 : r_tcnt + 8'd1;
      end
      // a coincident flush discards the response
      if ((r_state == S_BUSY) && bus.mem_ack && !bus.flush) begin
        r_instr      <= bus.mem_data;
        r_instr_addr <= r_addr;
        r_cnt        <= r_cnt + 1'b1;
      end
    end
  end

  assign bus.mem_addr    = r_addr;
  assign bus.instr       = r_instr;
  assign bus.instr_addr  = r_instr_addr;
  assign bus.err_align   = r_err_align;
  assign bus.err_timeout = r_err_to;
  assign bus.fetch_cnt   = r_cnt;

endmodule

// File: tb/tb_ifetch_unit.sv
// Randomized plus directed bench for ifetch_unit against a transaction-level
// model of the fetch rules (one outstanding read, one held word).
module tb_ifetch_unit;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ifetch_if #(.CNT_W(CNT_W)) bus ();
  ifetch_unit #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: outstanding read, held word, pending error pulses
  bit          m_pending;
  bit          m_holding;
  bit          m_ea;
  bit          m_et;
  int          m_waited;
  logic [31:0] m_req;
  logic [31:0] m_word;
  logic [31:0] m_word_addr;
  int          m_done;

  // current stimulus
  bit          d_av, d_fl, d_ack, d_rdy;
  logic [31:0] d_addr, d_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit model_ready();
    return !m_pending && (!m_holding || d_rdy) && !d_fl;
  endfunction

  task automatic model_clear();
    m_pending = 0; m_holding = 0; m_ea = 0; m_et = 0; m_waited = 0;
    m_req = '0; m_word = '0; m_word_addr = '0; m_done = 0;
  endtask

  task automatic model_step();
    bit acc;
    acc  = d_av && model_ready();
    m_ea = 0;
    m_et = 0;
    if (d_fl) begin
      m_pending = 0; m_holding = 0; m_waited = 0;
    end else if (m_pending) begin
      if (d_ack) begin
        m_pending   = 0;
        m_holding   = 1;
        m_word      = d_data;
        m_word_addr = m_req;
        m_done      = (m_done + 1) % (1 << CNT_W);
      end else if (m_waited == TIMEOUT - 1) begin
        m_pending = 0;
        m_et      = 1;
      end else begin
        m_waited++;
      end
    end else begin
      if (m_holding && d_rdy) m_holding = 0;
      if (acc) begin
        if (d_addr[1:0] != 2'b00) m_ea = 1;
        else begin
          m_pending = 1; m_req = d_addr; m_waited = 0;
        end
      end
    end
  endtask

  task automatic check_outputs();
    chk("addr_ready",  32'(bus.addr_ready),  32'(model_ready()));
    chk("mem_rd",      32'(bus.mem_rd),      32'(m_pending));
    chk("mem_addr",    bus.mem_addr,         m_req);
    chk("instr_valid", 32'(bus.instr_valid), 32'(m_holding));
    chk("instr",       bus.instr,            m_word);
    chk("instr_addr",  bus.instr_addr,       m_word_addr);
    chk("err_align",   32'(bus.err_align),   32'(m_ea));
    chk("err_timeout", 32'(bus.err_timeout), 32'(m_et));
    chk("fetch_cnt",   32'(bus.fetch_cnt),   32'(m_done));
  endtask

  // one clock cycle: drive, check mid-cycle, advance model at the edge
  task automatic cycle(input bit av, input logic [31:0] addr, input bit fl,
                       input bit ack, input logic [31:0] data, input bit rdy);
    d_av = av; d_addr = addr; d_fl = fl; d_ack = ack; d_data = data; d_rdy = rdy;
    bus.addr_valid  = av;
    bus.addr_in     = addr;
    bus.flush       = fl;
    bus.mem_ack     = ack;
    bus.mem_data    = data;
    bus.instr_ready = rdy;
    #3;
    check_outputs();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    bus.addr_valid = 0; bus.addr_in = '0; bus.flush = 0;
    bus.mem_ack = 0; bus.mem_data = '0; bus.instr_ready = 0;
    d_av = 0; d_addr = '0; d_fl = 0; d_ack = 0; d_data = '0; d_rdy = 0;
    rst = 1'b1;
    #2;
    chk("rst_ready", 32'(bus.addr_ready),  0);
    chk("rst_rd",    32'(bus.mem_rd),      0);
    chk("rst_maddr", bus.mem_addr,         0);
    chk("rst_valid", 32'(bus.instr_valid), 0);
    chk("rst_instr", bus.instr,            0);
    chk("rst_iaddr", bus.instr_addr,       0);
    chk("rst_cnt",   32'(bus.fetch_cnt),   0);
    chk("rst_ea",    32'(bus.err_align),   0);
    chk("rst_et",    32'(bus.err_timeout), 0);
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(bus.addr_ready), 1);
  endtask

  initial begin
    int rd_cycles;
    int cnt_before;
    bit stall;
    logic [31:0] a;

    model_clear();
    @(posedge clk);
    #1;
    do_reset();

    // basic aligned fetch with ACK in first BUSY cycle
    cycle(1, 32'h40, 0, 0, 0, 0);
    chk("d31_rd",    32'(bus.mem_rd), 1);
    chk("d31_maddr", bus.mem_addr, 32'h40);
    cycle(0, 0, 0, 1, 32'h8C220004, 0);
    chk("d31_valid", 32'(bus.instr_valid), 1);
    chk("d31_instr", bus.instr, 32'h8C220004);
    chk("d31_iaddr", bus.instr_addr, 32'h40);
    chk("d31_cnt",   32'(bus.fetch_cnt), 1);
    cycle(0, 0, 0, 0, 0, 0);

    // consume and re-accept back to back
    cycle(1, 32'h44, 0, 0, 0, 1);
    chk("d34_rd",    32'(bus.mem_rd), 1);
    chk("d34_maddr", bus.mem_addr, 32'h44);
    chk("d34_valid", 32'(bus.instr_valid), 0);
    cycle(0, 0, 0, 1, 32'h12345678, 0);
    cycle(0, 0, 0, 0, 0, 1);

    // misaligned address
    cnt_before = int'(bus.fetch_cnt);
    cycle(1, 32'h42, 0, 0, 0, 0);
    chk("d32_ea",  32'(bus.err_align), 1);
    chk("d32_rd",  32'(bus.mem_rd), 0);
    cycle(0, 0, 0, 0, 0, 0);
    chk("d32_ea_once", 32'(bus.err_align), 0);
    chk("d32_cnt", 32'(bus.fetch_cnt), 32'(cnt_before));

    // timeout: read held for exactly TIMEOUT cycles
    cycle(1, 32'h80, 0, 0, 0, 0);
    rd_cycles = 0;
    for (int i = 0; i < TIMEOUT + 4; i++) begin
      if (bus.mem_rd) rd_cycles++;
      cycle(0, 0, 0, 0, 0, 0);
    end
    chk("d33_rd_cycles", 32'(rd_cycles), TIMEOUT);
    chk("d33_ready", 32'(bus.addr_ready), 1);

    // flush coincident with ACK
    cnt_before = int'(bus.fetch_cnt);
    cycle(1, 32'h100, 0, 0, 0, 0);
    cycle(0, 0, 1, 1, 32'hDEADBEEF, 0);
    chk("d35_valid", 32'(bus.instr_valid), 0);
    chk("d35_rd",    32'(bus.mem_rd), 0);
    chk("d35_cnt",   32'(bus.fetch_cnt), 32'(cnt_before));
    cycle(0, 0, 0, 0, 0, 0);

    // reset in BUSY, then a stray ACK
    cycle(1, 32'h200, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    do_reset();
    cycle(0, 0, 0, 1, 32'hCAFEF00D, 0);
    chk("d36_valid", 32'(bus.instr_valid), 0);
    chk("d36_instr", bus.instr, 0);
    chk("d36_cnt",   32'(bus.fetch_cnt), 0);

    // randomized traffic with periodic no-ACK stretches
    stall = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 150 == 0) stall = ($urandom_range(0, 2) == 0);
      a = $urandom();
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      cycle($urandom_range(0, 1) == 1, a,
            $urandom_range(0, 19) == 0,
            stall ? 1'b0 : ($urandom_range(0, 2) == 0),
            $urandom(),
            $urandom_range(0, 1) == 1);
      if (i == 1500) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
